c17_error_monitor: RTL and testbench



---
 rtl/c17_error_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_c17_error_monitor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/c17_error_monitor.sv
// c17_error_monitor
// Stimulus/response partner for exact vs. approximate c17-class netlists.
// Sweeps every N_IN-bit input vector, compares the two responses after LAT
// cycles and accumulates saturating error statistics.
//
// Ports:
//   CLK             - single clock, rising edge
//   RST             - synchronous active-high reset
//   START           - one-cycle sweep request (accepted in IDLE or DONE)
//   ABORT           - ends a running sweep early, statistics retained
//   EXACT_IN        - response of the exact circuit   (bit1 OUT_a, bit0 OUT_b)
//   APPROX_IN       - response of the approximate circuit
//   PAT_OUT         - vector driven to both circuits (bit4 IN_a .. bit0 IN_e)
//   BUSY / DONE     - sweep in progress / sweep finished
//   ERR_VEC_CNT     - vectors with any mismatching output bit
//   ERR_A_CNT       - mismatches on output bit 1
//   ERR_B_CNT       - mismatches on output bit 0
//   FIRST_ERR_PAT   - first vector of the sweep that mismatched
//   FIRST_ERR_VALID - FIRST_ERR_PAT holds a captured vector
module c17_error_monitor #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 2,
    parameter int LAT   = 1,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [N_OUT-1:0] EXACT_IN,
    input  logic [N_OUT-1:0] APPROX_IN,
    output logic [N_IN-1:0]  PAT_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] ERR_VEC_CNT,
    output logic [CNT_W-1:0] ERR_A_CNT,
    output logic [CNT_W-1:0] ERR_B_CNT,
    output logic [N_IN-1:0]  FIRST_ERR_PAT,
    output logic             FIRST_ERR_VALID
);

    // The tag pipeline keeps at least one stage so LAT = 0 needs no special types.
    localparam int LAT_D = (LAT == 0) ? 1 : LAT;
    localparam logic [N_IN-1:0]  PAT_LAST = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Saturating increment: a full counter stays at its maximum.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && (v != CNT_MAX)) begin
            r = v + CNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t                      state_q, state_d;
    logic [N_IN-1:0]             pat_q, pat_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [LAT_D-1:0]            vld_q, vld_d;
    logic [LAT_D-1:0][N_IN-1:0]  tag_q, tag_d;
    logic [CNT_W-1:0]            vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]            a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0]            b_cnt_q, b_cnt_d;
    logic [N_IN-1:0]             first_pat_q, first_pat_d;
    logic                        first_vld_q, first_vld_d;

    logic                        start_acc_s;
    logic                        abort_acc_s;
    logic                        emerge_vld_s;
    logic [N_IN-1:0]             emerge_tag_s;
    logic [N_OUT-1:0]            mism_s;

    assign start_acc_s  = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign abort_acc_s  = ABORT && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    // With no latency the response belongs to the vector on PAT_OUT right now.
    assign emerge_vld_s = (LAT == 0) ? (state_q == ST_RUN) : vld_q[LAT_D-1];
    assign emerge_tag_s = (LAT == 0) ? pat_q : tag_q[LAT_D-1];
    assign mism_s       = EXACT_IN ^ APPROX_IN;

    // Next-state, pattern, tag pipeline and statistics computation.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        vec_cnt_d   = vec_cnt_q;
        a_cnt_d     = a_cnt_q;
        b_cnt_d     = b_cnt_q;
        first_pat_d = first_pat_q;
        first_vld_d = first_vld_q;

        // Each issued vector enters the pipeline tagged with its pattern.
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = (state_q == ST_RUN);
        tag_d[0] = pat_q;
        for (int i = 1; i < LAT_D; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        // A tag leaving the pipeline is compared even on an abort edge.
        if (emerge_vld_s) begin
            a_cnt_d   = sat_inc(a_cnt_q, mism_s[1]);
            b_cnt_d   = sat_inc(b_cnt_q, mism_s[0]);
            vec_cnt_d = sat_inc(vec_cnt_q, |mism_s);
            if ((|mism_s) && !first_vld_q) begin
                first_pat_d = emerge_tag_s;
                first_vld_d = 1'b1;
            end else begin
                first_pat_d = first_pat_q;
                first_vld_d = first_vld_q;
            end
        end else begin
            vec_cnt_d = vec_cnt_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    state_d     = ST_RUN;
                    pat_d       = '0;
                    vec_cnt_d   = '0;
                    a_cnt_d     = '0;
                    b_cnt_d     = '0;
                    first_pat_d = '0;
                    first_vld_d = 1'b0;
                    vld_d       = '0;
                    tag_d       = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (abort_acc_s) begin
                    state_d = ST_DONE;
                    vld_d   = '0;
                    tag_d   = '0;
                end else if (pat_q == PAT_LAST) begin
                    state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    pat_d = pat_q + N_IN'(1);
                end
            end
            ST_DRAIN: begin
                if (abort_acc_s) begin
                    state_d = ST_DONE;
                    vld_d   = '0;
                    tag_d   = '0;
                end else if (emerge_vld_s && (emerge_tag_s == PAT_LAST)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the state one cycle later; DONE drops on the START edge.
        busy_d = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done_d = (state_q == ST_DONE) && !start_acc_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            tag_q       <= '0;
            vec_cnt_q   <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            first_pat_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            vec_cnt_q   <= vec_cnt_d;
            a_cnt_q     <= a_cnt_d;
            b_cnt_q     <= b_cnt_d;
            first_pat_q <= first_pat_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign PAT_OUT         = pat_q;
    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ERR_VEC_CNT     = vec_cnt_q;
    assign ERR_A_CNT       = a_cnt_q;
    assign ERR_B_CNT       = b_cnt_q;
    assign FIRST_ERR_PAT   = first_pat_q;
    assign FIRST_ERR_VALID = first_vld_q;

endmodule

// File: tb/tb_c17_error_monitor.sv
// Bench for c17_error_monitor: three monitors (LAT = 1, 2, 0) and one
// CNT_W = 3 monitor run side by side from shared START/ABORT/RST. Each has
// its own c17 model whose response is delayed by that monitor's latency.
module tb_c17_error_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    int         mode_r = 0;

    int         checks = 0;
    int         errors = 0;

    // index 0: LAT=1, 1: LAT=2, 2: LAT=0
    logic [4:0] pat [3];
    logic       busy [3];
    logic       done_s [3];
    logic [5:0] ev [3];
    logic [5:0] ea [3];
    logic [5:0] eb [3];
    logic [4:0] fp [3];
    logic       fv [3];
    logic [1:0] exi [3];
    logic [1:0] api [3];

    // saturating instance (LAT=1, CNT_W=3)
    logic [4:0] s_pat;
    logic       s_busy, s_done, s_fv;
    logic [2:0] s_ev, s_ea, s_eb;
    logic [4:0] s_fp;
    logic [1:0] s_exi, s_api;

    logic [4:0] d1_r = 5'd0;
    logic [4:0] d2a_r = 5'd0;
    logic [4:0] d2b_r = 5'd0;
    logic [4:0] ds_r = 5'd0;

    always #5 clk = ~clk;

    // ISCAS c17: IN_a..IN_e = nets 1,2,3,6,7; result {N22, N23}.
    function automatic logic [1:0] c17(input logic [4:0] p);
        logic a, b, c, d, e, n10, n11, n16, n19;
        a = p[4]; b = p[3]; c = p[2]; d = p[1]; e = p[0];
        n10 = ~(a & c);
        n11 = ~(c & d);
        n16 = ~(b & n11);
        n19 = ~(n11 & e);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    function automatic logic [1:0] approx(input int m, input logic [4:0] p);
        logic [1:0] x;
        x = c17(p);
        case (m)
            1: x = x ^ 2'b10;
            2: begin
                if (p == 5'd19) x = x ^ 2'b01;
                else if (p == 5'd25) x = x ^ 2'b11;
            end
            3: x = ~x;
            default: x = c17(p);
        endcase
        return x;
    endfunction

    // Response delay lines modelling circuit latency.
    always @(posedge clk) begin
        d1_r  <= pat[0];
        d2a_r <= pat[1];
        d2b_r <= d2a_r;
        ds_r  <= s_pat;
    end

    assign exi[0] = c17(d1_r);
    assign api[0] = approx(mode_r, d1_r);
    assign exi[1] = c17(d2b_r);
    assign api[1] = approx(mode_r, d2b_r);
    assign exi[2] = c17(pat[2]);
    assign api[2] = approx(mode_r, pat[2]);
    assign s_exi  = c17(ds_r);
    assign s_api  = approx(mode_r, ds_r);

    c17_error_monitor #(.N_IN(5), .N_OUT(2), .LAT(1), .CNT_W(6)) u_l1 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .EXACT_IN(exi[0]), .APPROX_IN(api[0]), .PAT_OUT(pat[0]),
        .BUSY(busy[0]), .DONE(done_s[0]), .ERR_VEC_CNT(ev[0]),
        .ERR_A_CNT(ea[0]), .ERR_B_CNT(eb[0]), .FIRST_ERR_PAT(fp[0]),
        .FIRST_ERR_VALID(fv[0]));

    c17_error_monitor #(.N_IN(5), .N_OUT(2), .LAT(2), .CNT_W(6)) u_l2 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .EXACT_IN(exi[1]), .APPROX_IN(api[1]), .PAT_OUT(pat[1]),
        .BUSY(busy[1]), .DONE(done_s[1]), .ERR_VEC_CNT(ev[1]),
        .ERR_A_CNT(ea[1]), .ERR_B_CNT(eb[1]), .FIRST_ERR_PAT(fp[1]),
        .FIRST_ERR_VALID(fv[1]));

    c17_error_monitor #(.N_IN(5), .N_OUT(2), .LAT(0), .CNT_W(6)) u_l0 (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .EXACT_IN(exi[2]), .APPROX_IN(api[2]), .PAT_OUT(pat[2]),
        .BUSY(busy[2]), .DONE(done_s[2]), .ERR_VEC_CNT(ev[2]),
        .ERR_A_CNT(ea[2]), .ERR_B_CNT(eb[2]), .FIRST_ERR_PAT(fp[2]),
        .FIRST_ERR_VALID(fv[2]));

    c17_error_monitor #(.N_IN(5), .N_OUT(2), .LAT(1), .CNT_W(3)) u_sat (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort),
        .EXACT_IN(s_exi), .APPROX_IN(s_api), .PAT_OUT(s_pat),
        .BUSY(s_busy), .DONE(s_done), .ERR_VEC_CNT(s_ev),
        .ERR_A_CNT(s_ea), .ERR_B_CNT(s_eb), .FIRST_ERR_PAT(s_fp),
        .FIRST_ERR_VALID(s_fv));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int mode;
        int restart_at;
        bit abort_w;
        int ea, eb, ev, efv, efp;
        int sa, sb, sv;
    } sweep_t;

    sweep_t tbl [5];
    int     done_at [3];
    int     walk_bad;
    int     exp_done [3];
    bit     found;

    initial begin
        tbl[0] = '{0,  0, 1'b0,  0,  0,  0, 0,  0, 0, 0, 0};
        tbl[1] = '{1,  0, 1'b0, 32,  0, 32, 1,  0, 7, 0, 7};
        tbl[2] = '{2, 10, 1'b0,  1,  2,  2, 1, 19, 1, 2, 2};
        tbl[3] = '{3,  0, 1'b0, 32, 32, 32, 1,  0, 7, 7, 7};
        tbl[4] = '{0,  0, 1'b1,  0,  0,  0, 0,  0, 0, 0, 0};
        exp_done[0] = 34;
        exp_done[1] = 35;
        exp_done[2] = 33;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pat", pat[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done_s[0], 0);
        check("rst_vec", ev[0], 0);
        check("rst_fv", fv[0], 0);
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            mode_r = tbl[r].mode;
            @(negedge clk);
            start = 1'b1;
            abort = tbl[r].abort_w;
            @(posedge clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            check("start_clr_vec", ev[0], 0);
            check("start_clr_fv", fv[0], 0);
            walk_bad = (pat[0] == 5'd0) ? 0 : 1;
            for (int i = 0; i < 3; i++) done_at[i] = 0;
            for (int n = 1; n <= 45; n++) begin
                if (n == tbl[r].restart_at) start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                if (int'(pat[0]) != ((n < 32) ? n : 31)) walk_bad++;
                for (int i = 0; i < 3; i++) begin
                    if (done_at[i] == 0 && done_s[i]) done_at[i] = n;
                end
            end
            check("pat_walk", walk_bad, 0);
            check("end_busy", busy[0], 0);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("done_time_%0d", i), done_at[i], exp_done[i]);
                check($sformatf("err_a_%0d", i), ea[i], tbl[r].ea);
                check($sformatf("err_b_%0d", i), eb[i], tbl[r].eb);
                check($sformatf("err_vec_%0d", i), ev[i], tbl[r].ev);
                check($sformatf("first_valid_%0d", i), fv[i], tbl[r].efv);
                check($sformatf("first_pat_%0d", i), fp[i], tbl[r].efp);
            end
            check("sat_a", s_ea, tbl[r].sa);
            check("sat_b", s_eb, tbl[r].sb);
            check("sat_vec", s_ev, tbl[r].sv);
        end

        // ABORT at PAT_OUT = 8 with every output bit wrong
        mode_r = 3;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge clk);
            #1;
            if (pat[0] == 5'd8) found = 1'b1;
        end
        check("abort_reach", found, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_vec_l1", ev[0], 8);
        check("abort_vec_l2", ev[1], 7);
        check("abort_vec_l0", ev[2], 9);
        check("abort_vec_sat", s_ev, 7);
        check("abort_pat_hold", pat[0], 8);
        @(posedge clk);
        #1;
        check("abort_done", done_s[0], 1);
        check("abort_busy", busy[0], 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_vec_kept", ev[0], 8);
        check("abort_pat_kept", pat[0], 8);

        // RST in the middle of a sweep
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_pat", pat[0], 0);
        check("mrst_vec", ev[0], 0);
        check("mrst_a", ea[0], 0);
        check("mrst_b", eb[0], 0);
        check("mrst_busy", busy[0], 0);
        check("mrst_done", done_s[0], 0);
        check("mrst_fv", fv[0], 0);
        repeat (2) @(posedge clk);
        #1;
        check("mrst_idle_pat", pat[0], 0);
        check("mrst_idle_busy", busy[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
